// File: rtl/spi_transaction_scheduler_if.sv
// Client and SPI-master signal bundle for spi_transaction_scheduler.
// The slave modport is the scheduler's view; the master modport is the surrounding logic.
interface spi_transaction_scheduler_if #(
    parameter int requesters = 4,
    parameter int bitcount   = 8
);
    logic [requesters-1:0]          req_valid;
    logic [requesters*bitcount-1:0] req_data;
    logic [requesters-1:0]          req_ready;
    logic [requesters-1:0]          rsp_valid;
    logic [bitcount-1:0]            rsp_data;
    logic                           rsp_error;
    logic [requesters-1:0]          ss;
    logic                           spi_trigger;
    logic [bitcount-1:0]            spi_tx_data;
    logic                           spi_done;
    logic [bitcount-1:0]            spi_rx_data;

    modport slave (
        input  req_valid, req_data, spi_done, spi_rx_data,
        output req_ready, rsp_valid, rsp_data, rsp_error, ss, spi_trigger, spi_tx_data
    );

    modport master (
        output req_valid, req_data, spi_done, spi_rx_data,
        input  req_ready, rsp_valid, rsp_data, rsp_error, ss, spi_trigger, spi_tx_data
    );
endinterface

// File: rtl/spi_transaction_scheduler.sv
// Round-robin scheduler sharing one SPI master among several requesters/slave selects.
// Define SPI_SCHEDULER_TIMEOUT_EN to abort frames whose spi_done never arrives.
module spi_transaction_scheduler #(
    parameter int requesters     = 4,
    parameter int bitcount       = 8,
    parameter int ss_polarity    = 1,
    parameter int gap_cycles     = 4,
    parameter int timeout_cycles = 1024
) (
    input  logic                          clock,
    input  logic                          reset_n,
    spi_transaction_scheduler_if.slave    bus
);

    localparam int                idx_w     = $clog2(requesters);
    localparam int                gap_w     = $clog2(gap_cycles + 1);
    localparam logic [idx_w-1:0]  last_idx  = idx_w'(requesters - 1);
    localparam logic [gap_w-1:0]  gap_last  = gap_w'(gap_cycles - 1);
    localparam logic              ss_active = (ss_polarity != 0);

    if (requesters < 2 || requesters > 8 || gap_cycles < 1 || timeout_cycles < 1) begin : g_param_check
        $error("spi_transaction_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RESPOND, GAP} state_t;

    state_t              state, next_state;
    logic [idx_w-1:0]    rr_pointer, grant, pick;
    logic                found;
    int                  cand;
    logic [bitcount-1:0] tx_data, rx_word;
    logic [gap_w-1:0]    gap_cnt;
    logic                timed_out;

`ifdef SPI_SCHEDULER_TIMEOUT_EN
    localparam int               to_w    = $clog2(timeout_cycles + 1);
    localparam logic [to_w-1:0]  to_last = to_w'(timeout_cycles - 1);

    logic [to_w-1:0] to_cnt;
    logic            err_flag;

    // A done arriving in the last allowed cycle still wins over the timeout.
    assign timed_out = (state == WAIT_DONE) && !bus.spi_done && (to_cnt == to_last);
`else
    assign timed_out = 1'b0;
`endif

    // First pending requester at or after rr_pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int k = 0; k < requesters; k++) begin
            cand = (int'(rr_pointer) + k) % requesters;
            if (!found && bus.req_valid[cand[idx_w-1:0]]) begin
                found = 1'b1;
                pick  = cand[idx_w-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (found)                     next_state = START;
            START:                                    next_state = WAIT_DONE;
            WAIT_DONE: if (bus.spi_done || timed_out) next_state = RESPOND;
            RESPOND:                                  next_state = GAP;
            GAP:       if (gap_cnt == gap_last)       next_state = IDLE;
            default:                                  next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = '0;
        bus.rsp_valid   = '0;
        bus.spi_trigger = 1'b0;
        bus.ss          = {requesters{~ss_active}};
        case (state)
            IDLE:      if (found && reset_n) bus.req_ready[pick] = 1'b1;
            START: begin
                bus.ss[grant]   = ss_active;
                bus.spi_trigger = 1'b1;
            end
            WAIT_DONE: bus.ss[grant]        = ss_active;
            RESPOND:   bus.rsp_valid[grant] = 1'b1;
            default: ;
        endcase
    end

    assign bus.spi_tx_data = tx_data;
    assign bus.rsp_data    = rx_word;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_pointer <= '0;
            grant      <= '0;
            tx_data    <= '0;
            rx_word    <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= pick;
                    tx_data <= bus.req_data[int'(pick)*bitcount +: bitcount];
                end
                START:     rr_pointer <= (grant == last_idx) ? '0 : grant + 1'b1;
                WAIT_DONE: begin
                    if (bus.spi_done)   rx_word <= bus.spi_rx_data;
                    else if (timed_out) rx_word <= '0;
                end
                RESPOND:   gap_cnt <= '0;
                GAP:       gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SPI_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt   <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                START:     to_cnt <= '0;
                WAIT_DONE: begin
                    to_cnt   <= to_cnt + 1'b1;
                    err_flag <= timed_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_error = (state == RESPOND) && err_flag;
`else
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_transaction_scheduler.sv
// Randomized scoreboard bench for spi_transaction_scheduler, plus an ss_polarity=0 instance.
// Expected grants, frame timing and responses come from a round-robin model in the monitor.
module tb_spi_transaction_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GAP = 4;
    localparam int TO  = 16;

    typedef struct {
        int           req;
        logic [W-1:0] data;
    } exp_t;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   epoch    = 0;
    int   done_delay;
    exp_t sb[$];

    // Monitor model state
    int           rr_ptr, cyc, trig_cyc, last_rsp_cyc, frame_sel, exp_grant;
    logic         in_frame, exp_trig, done_prev;
    logic [W-1:0] exp_tx, last_data;

    spi_transaction_scheduler_if #(.requesters(N), .bitcount(W)) bus ();
    spi_transaction_scheduler_if #(.requesters(N), .bitcount(W)) bus0 ();

    spi_transaction_scheduler #(
        .requesters(N), .bitcount(W), .ss_polarity(1), .gap_cycles(GAP), .timeout_cycles(TO)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    spi_transaction_scheduler #(
        .requesters(N), .bitcount(W), .ss_polarity(0), .gap_cycles(GAP), .timeout_cycles(TO)
    ) u_dut_p0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External SPI master: answers each trigger with tx ^ 8'h99 after a delay.
    initial begin : spi_master_model
        int d;
        int my_epoch;
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = W'($urandom);
        forever begin
            @(negedge clock);
            if (reset_n && bus.spi_trigger) begin
                my_epoch = epoch;
                d = (done_delay > 0) ? done_delay :
                    (done_delay < 0) ? 40 : int'($urandom_range(1, 12));
                for (int k = 0; k < d; k++) begin
                    @(posedge clock);
                    if (epoch != my_epoch) break;
                end
                if (epoch == my_epoch) begin
                    #1;
                    bus.spi_done    = 1'b1;
                    bus.spi_rx_data = bus.spi_tx_data ^ 8'h99;
                    @(posedge clock);
                    #1;
                    bus.spi_done    = 1'b0;
                    bus.spi_rx_data = W'($urandom);
                end
            end
        end
    end

    // Monitor: predicts every cycle's grant, trigger, ss and response from round-robin rules.
    always @(negedge clock) begin : monitor
        logic [N-1:0] act_mask;
        logic [N-1:0] exp_mask;
        logic [N-1:0] exp_ready;
        logic         timed;
        logic         rsp_due;
        int           j;
        exp_t         e;
        if (!reset_n) begin
            sb.delete();
            rr_ptr = 0; cyc = 0; last_rsp_cyc = -100;
            in_frame = 1'b0; exp_trig = 1'b0; done_prev = 1'b0; last_data = '0;
            check("reset ss", bus.ss, 0);
            check("reset req_ready", bus.req_ready, 0);
            check("reset rsp_valid", bus.rsp_valid, 0);
            check("reset spi_trigger", bus.spi_trigger, 0);
        end else begin
            cyc++;
`ifdef SPI_SCHEDULER_TIMEOUT_EN
            timed = in_frame && !done_prev && (cyc - trig_cyc == TO + 1);
`else
            timed = 1'b0;
`endif
            rsp_due = in_frame && (done_prev || timed);
            if (rsp_due) begin
                in_frame     = 1'b0;
                last_rsp_cyc = cyc;
            end
            check("rsp_valid timing", bus.rsp_valid != 0, rsp_due);
            if (bus.rsp_valid != 0) begin
                if (sb.size() == 0) begin
                    check("rsp_valid unexpected", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    last_data = timed ? '0 : e.data;
                    check("rsp_valid requester", bus.rsp_valid, 1 << e.req);
                    check("rsp_data", bus.rsp_data, last_data);
                    check("rsp_error", bus.rsp_error, timed);
                end
            end else begin
                check("rsp_data hold", bus.rsp_data, last_data);
            end

            check("spi_trigger", bus.spi_trigger, exp_trig);
            if (exp_trig) begin
                check("spi_tx_data", bus.spi_tx_data, exp_tx);
                in_frame  = 1'b1;
                trig_cyc  = cyc;
                frame_sel = exp_grant;
                exp_trig  = 1'b0;
            end

            act_mask = bus.ss;
            exp_mask = in_frame ? N'(1 << frame_sel) : '0;
            check("ss active set", act_mask, exp_mask);
            done_prev = in_frame && bus.spi_done && (cyc != trig_cyc);

            exp_ready = '0;
            if (!in_frame && (cyc - last_rsp_cyc > GAP)) begin
                for (int k = 0; k < N; k++) begin
                    j = (rr_ptr + k) % N;
                    if (exp_ready == 0 && bus.req_valid[j]) exp_ready = N'(1 << j);
                end
            end
            check("req_ready", bus.req_ready, exp_ready);
            if (exp_ready != 0) begin
                for (int k = 0; k < N; k++) if (exp_ready[k]) exp_grant = k;
                exp_tx   = bus.req_data[exp_grant*W +: W];
                exp_trig = 1'b1;
                rr_ptr   = (exp_grant + 1) % N;
                sb.push_back('{req: exp_grant, data: exp_tx ^ 8'h99});
            end
        end
    end

    // Hold requests, dropping each one the cycle after it is accepted.
    task automatic serve(input int cycles);
        logic [N-1:0] acc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            acc = bus.req_ready;
            @(posedge clock);
            #1;
            bus.req_valid = bus.req_valid & ~acc;
        end
    endtask

    task automatic run_random(input int cycles);
        logic [N-1:0] acc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            acc = bus.req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req_valid[i]         = 1'b1;
                        bus.req_data[i*W +: W]   = W'($urandom);
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        done_delay = 3;
        bus.req_valid = '0; bus.req_data = '0;
        bus0.req_valid = '0; bus0.req_data = '0; bus0.spi_done = 1'b0; bus0.spi_rx_data = '0;
        #2;
        check("reset spi_tx_data", bus.spi_tx_data, 0);
        check("reset rsp_data", bus.rsp_data, 0);
        check("reset rsp_error", bus.rsp_error, 0);
        check("p0 reset ss idle", bus0.ss, 4'b1111);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Active-low selects on the second instance
        @(posedge clock); #1;
        bus0.req_valid = 4'b0001; bus0.req_data = 32'h0000_00A5;
        @(negedge clock);
        check("p0 req_ready", bus0.req_ready, 4'b0001);
        check("p0 ss before frame", bus0.ss, 4'b1111);
        @(posedge clock); #1 bus0.req_valid = '0;
        @(negedge clock);
        check("p0 spi_trigger", bus0.spi_trigger, 1);
        check("p0 spi_tx_data", bus0.spi_tx_data, 8'hA5);
        check("p0 ss in frame", bus0.ss, 4'b1110);
        repeat (4) begin
            @(negedge clock);
            check("p0 ss in frame", bus0.ss, 4'b1110);
            check("p0 trigger one cycle", bus0.spi_trigger, 0);
        end
        @(posedge clock); #1;
        bus0.spi_done = 1'b1; bus0.spi_rx_data = 8'h3C;
        @(negedge clock);
        check("p0 ss at done", bus0.ss, 4'b1110);
        @(posedge clock); #1;
        bus0.spi_done = 1'b0; bus0.spi_rx_data = 8'h00;
        @(negedge clock);
        check("p0 rsp_valid", bus0.rsp_valid, 4'b0001);
        check("p0 rsp_data", bus0.rsp_data, 8'h3C);
        check("p0 ss at respond", bus0.ss, 4'b1111);
        repeat (4) begin
            @(negedge clock);
            check("p0 ss gap", bus0.ss, 4'b1111);
            check("p0 rsp_data hold", bus0.rsp_data, 8'h3C);
        end

        // Single request, done 20 cycles after trigger
        done_delay = 20;
        @(posedge clock); #1;
        bus.req_valid = 4'b0001; bus.req_data = 32'h0000_00A5;
        serve(3);
        repeat (40) @(negedge clock);

        // All requesters held continuously
        done_delay = 3;
        @(posedge clock); #1;
        bus.req_data = 32'h4433_2211; bus.req_valid = 4'b1111;
        repeat (55) @(posedge clock);
        #1 bus.req_valid = '0;
        repeat (25) @(negedge clock);

        // Pointer at 3, requesters 0 and 2 pending: wrap to 0 first
        @(posedge clock); #1;
        bus.req_data = 32'h00C7_0000; bus.req_valid = 4'b0100;
        serve(30);
        @(posedge clock); #1;
        bus.req_data = 32'h00E1_0018; bus.req_valid = 4'b0101;
        serve(50);

        // Reset in the middle of a frame granted to requester 2
        done_delay = 30;
        @(posedge clock); #1;
        bus.req_data = 32'h005E_0000; bus.req_valid = 4'b0100;
        serve(2);
        repeat (5) @(negedge clock);
        check("ss before reset", bus.ss, 4'b0100);
        #2 reset_n = 1'b0;
        epoch++;
        #1;
        check("async reset ss", bus.ss, 0);
        check("async reset rsp_valid", bus.rsp_valid, 0);
        check("async reset spi_tx_data", bus.spi_tx_data, 0);
        check("async reset rsp_data", bus.rsp_data, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        done_delay = 3;
        bus.req_data = 32'h9100_7300; bus.req_valid = 4'b1010;
        serve(60);

        // Random traffic with random done latency and withdrawals
        done_delay = 0;
        run_random(1500);
        #1 bus.req_valid = '0;
        done_delay = 3;
        repeat (40) @(negedge clock);

`ifdef SPI_SCHEDULER_TIMEOUT_EN
        // Silent master: timeout response, then a late done that must be ignored
        done_delay = -1;
        @(posedge clock); #1;
        bus.req_data = 32'h0000_005A; bus.req_valid = 4'b0001;
        serve(80);
        done_delay = 3;
`endif

        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
